// File: rtl/store_write_buffer_if.sv
// Store-side, forwarding and memory-side signals of the store write buffer.
// The slave modport is the buffer; the master modport is the core/memory side.
interface store_write_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic [AW-1:0] lookup_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;

  modport slave (
    input  memwrite, dataadr, writedata, lookup_addr, mem_ready,
    output stall, fwd_hit, fwd_data, mem_valid, mem_addr, mem_wdata
  );

  modport master (
    output memwrite, dataadr, writedata, lookup_addr, mem_ready,
    input  stall, fwd_hit, fwd_data, mem_valid, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store write buffer between the core store port and data memory,
// with word-granular store-to-load forwarding from buffered entries.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  store_write_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     align_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          align_err_q, align_err_d;

  logic          full;
  logic          aligned;
  logic          push;
  logic          pop;
  logic          fwd_hit_c;
  logic [DW-1:0] fwd_data_c;
  logic [PW-1:0] fwd_idx;
  logic          unused_lookup_lsbs;

  assign full    = (count_q == CW'(DEPTH));
  assign aligned = (bus.dataadr[1:0] == 2'b00);
  assign push    = bus.memwrite & ~full & aligned;
  assign pop     = ~empty_q & bus.mem_ready;

  // Next-state for storage, pointers, occupancy and the sticky alignment flag.
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    align_err_d = align_err_q;
    if (push) begin
      addr_d[tail_q] = bus.dataadr;
      data_d[tail_q] = bus.writedata;
      tail_d         = PW'(tail_q + PW'(1));
    end
    if (pop) begin
      head_d = PW'(head_q + PW'(1));
    end
    count_d = CW'(count_q + CW'(push) - CW'(pop));
    empty_d = (count_d == '0);
    if (bus.memwrite && !aligned) begin
      align_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      align_err_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      align_err_q <= align_err_d;
    end
  end

  // Scan oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = PW'(head_q + PW'(k));
      if ((CW'(k) < count_q) &&
          (addr_q[fwd_idx][AW-1:2] == bus.lookup_addr[AW-1:2])) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = data_q[fwd_idx];
      end
    end
  end

  assign unused_lookup_lsbs = ^bus.lookup_addr[1:0];

  assign bus.stall     = bus.memwrite & full;
  assign bus.fwd_hit   = fwd_hit_c;
  assign bus.fwd_data  = fwd_data_c;
  assign bus.mem_valid = ~empty_q;
  assign bus.mem_addr  = addr_q[head_q];
  assign bus.mem_wdata = data_q[head_q];
  assign count         = count_q;
  assign empty         = empty_q;
  assign align_err     = align_err_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: queue-based reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       empty;
  logic       align_err;

  store_write_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .count     (count),
    .empty     (empty),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_err;
  ent_t mq[$];
  ent_t dl[$];
  logic m_align;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted stores plus log of what memory accepted.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_align = 1'b0;
    end else begin
      automatic bit full  = (mq.size() == DEPTH);
      automatic bit pop   = (mq.size() > 0) && bus.mem_ready;
      automatic bit alig  = (bus.dataadr[1:0] == 2'b00);
      automatic bit push  = bus.memwrite && !full && alig;
      automatic ent_t e;
      if (bus.memwrite && !alig) m_align = 1'b1;
      if (pop) dl.push_back(mq.pop_front());
      if (push) begin
        e.a = bus.dataadr;
        e.d = bus.writedata;
        mq.push_back(e);
      end
    end
  end

  // Compare process: every outputs-meaningful cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      automatic logic          e_hit = 1'b0;
      automatic logic [DW-1:0] e_fd  = '0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].a[AW-1:2] == bus.lookup_addr[AW-1:2]) begin
          e_hit = 1'b1;
          e_fd  = mq[i].d;
        end
      end
      chk("mem_valid", 64'(bus.mem_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("mem_addr",  64'(bus.mem_addr),  64'(mq[0].a));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(mq[0].d));
      end
      chk("count",     64'(count),         64'(mq.size()));
      chk("empty",     64'(empty),         64'(mq.size() == 0));
      chk("stall",     64'(bus.stall),     64'(bus.memwrite && mq.size() == DEPTH));
      chk("align_err", 64'(align_err),     64'(m_align));
      chk("fwd_hit",   64'(bus.fwd_hit),   64'(e_hit));
      chk("fwd_data",  64'(bus.fwd_data),  64'(e_fd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
  endtask

  // Hold a store until the buffer accepts it; a timeout counts as a failure.
  task automatic store_retry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    drive(1'b1, a, d);
    for (int c = 0; c < 20 && !ok; c++) begin
      #2;
      ok = !bus.stall;
      tick();
    end
    if (!ok) chk("store_timeout", 64'(0), 64'(1));
    drive(1'b0, '0, '0);
  endtask

  initial begin
    int base;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, '0, '0);
    bus.lookup_addr = 32'h0;
    bus.mem_ready   = 1'b0;
    #22;
    reset = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
    chk("rst_count",     64'(count),         64'(0));
    chk("rst_empty",     64'(empty),         64'(1));
    chk("rst_align",     64'(align_err),     64'(0));
    chk("rst_stall",     64'(bus.stall),     64'(0));
    bus.mem_ready = 1'b1;
    tick(); tick();
    chk("idle_empty", 64'(empty), 64'(1));

    // sw $5,20($0) with $5 = 0
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'd20, 32'd0);
    tick();
    drive(1'b0, '0, '0);
    chk("sw_valid", 64'(bus.mem_valid), 64'(1));
    chk("sw_addr",  64'(bus.mem_addr),  64'(20));
    chk("sw_count", 64'(count),         64'(1));
    bus.mem_ready = 1'b1;
    tick();
    chk("sw_empty", 64'(empty), 64'(1));
    chk("sw_dl",    64'(dl.size() == 1 && dl[0].a == 20 && dl[0].d == 0), 64'(1));

    // Fill to DEPTH, then a fifth store stalls until space frees
    bus.mem_ready = 1'b0;
    base = dl.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + 32'(4 * i), 32'(i + 1));
      tick();
    end
    drive(1'b1, 32'h20, 32'd5);
    #1;
    chk("fill_count", 64'(count),     64'(4));
    chk("fill_stall", 64'(bus.stall), 64'(1));
    tick();
    chk("fill_noacc", 64'(count),     64'(4));
    bus.mem_ready = 1'b1;
    store_retry(32'h20, 32'd5);
    for (int c = 0; c < 8; c++) tick();
    chk("fill_dl_n", 64'(dl.size() - base), 64'(5));
    for (int i = 0; i < 5 && base + i < dl.size(); i++) begin
      chk("fill_dl_a", 64'(dl[base + i].a), 64'(32'h10 + 32'(4 * i)));
      chk("fill_dl_d", 64'(dl[base + i].d), 64'(i + 1));
    end

    // Forwarding picks the youngest matching word
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h40, 32'hAAAA); tick();
    drive(1'b1, 32'h40, 32'hBBBB); tick();
    drive(1'b0, '0, '0);
    bus.lookup_addr = 32'h42;
    #1;
    chk("fwd_hit_42",  64'(bus.fwd_hit),  64'(1));
    chk("fwd_data_42", 64'(bus.fwd_data), 64'(32'hBBBB));
    bus.lookup_addr = 32'h44;
    #1;
    chk("fwd_hit_44",  64'(bus.fwd_hit),  64'(0));
    chk("fwd_data_44", 64'(bus.fwd_data), 64'(0));
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();

    // Misaligned store is dropped; then push/pop pairs across pointer wrap
    drive(1'b1, 32'h15, 32'h77); tick();
    drive(1'b0, '0, '0);
    chk("mis_align", 64'(align_err), 64'(1));
    chk("mis_count", 64'(count),     64'(0));
    base = dl.size();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'(100 + i));
      tick();
      chk("wrap_cnt_le1", 64'(count <= 3'd1), 64'(1));
    end
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("wrap_dl_n", 64'(dl.size() - base), 64'(10));
    for (int i = 0; i < 10 && base + i < dl.size(); i++)
      chk("wrap_dl_d", 64'(dl[base + i].d), 64'(100 + i));
    chk("mis_sticky", 64'(align_err), 64'(1));

    // Randomized phase
    for (int c = 0; c < 400; c++) begin
      automatic logic [AW-1:0] a = 32'(($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
      drive(1'($urandom_range(0, 1)), a, $urandom);
      bus.mem_ready   = ($urandom_range(0, 2) == 0);
      bus.lookup_addr = 32'(($urandom_range(0, 8)) << 2) | 32'($urandom_range(0, 3));
      tick();
    end

    // Reset between edges mid-drain drops mem_valid immediately
    drive(1'b0, '0, '0);
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'(i + 9)); tick();
    end
    drive(1'b0, '0, '0);
    chk("mid_count3", 64'(count), 64'(3));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid0", 64'(bus.mem_valid), 64'(0));
    chk("mid_count0", 64'(count),         64'(0));
    chk("mid_align0", 64'(align_err),     64'(0));
    base = dl.size();
    #3;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("mid_nostale", 64'(dl.size() - base), 64'(0));
    chk("mid_empty",   64'(empty),            64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the single-cycle MIPS core's store port (memwrite / dataadr / writedata) and upstream of the data memory.
- Captures each store into a small in-order FIFO and drains entries to memory over a valid/ready handshake, so a slow memory stalls the core only when the buffer is full.
- Provides word-address store-to-load forwarding, so a load that follows a buffered store to the same word returns the buffered data.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  core store strobe for the current cycle.
- dataadr  in  AW  core store byte address.
- writedata  in  DW  core store data.
- stall  out  1  core must hold the current store; combinational, equals memwrite & full.
- lookup_addr  in  AW  load byte address for forwarding.
- fwd_hit  out  1  combinational; a buffered entry matches lookup_addr.
- fwd_data  out  DW  data of the youngest matching entry; 0 when no hit.
- mem_valid  out  1  head entry is presented to memory.
- mem_addr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  memory accepts the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.
- align_err  out  1  sticky flag; a misaligned store was dropped.

Behaviour:
- Reset asserted (reset == 0), asynchronously:
  - all entries invalid; head, tail and count cleared to 0.
  - mem_valid = 0, mem_addr = 0, mem_wdata = 0.
  - align_err = 0, empty = 1, stall = 0, fwd_hit = 0, fwd_data = 0.
  - Pending stores are discarded.
  - Reset assertion mid-drain drops mem_valid immediately, without waiting for a clock edge.
- Storage: circular array of DEPTH entries {addr, data}, with head and tail pointers that wrap modulo DEPTH. Occupancy is tracked by count, so full (count == DEPTH) is distinguishable from empty.
- Push condition: memwrite & ~full & (dataadr[1:0] == 2'b00).
  - Entry written at tail; tail advances; count increments on the same edge.
- Misaligned store (memwrite with dataadr[1:0] != 0):
  - not enqueued; align_err set on the next edge and held until reset.
  - stall is not asserted for a misaligned store unless the buffer is full.
- Full: stall = 1 while memwrite is high. No push occurs, even when a pop happens in the same cycle; the core retries next cycle. There is no same-cycle bypass when full.
- Drain side:
  - mem_valid = ~empty; mem_addr and mem_wdata come from a direct read of the head entry.
  - Pop on mem_valid & mem_ready: head advances, count decrements.
  - While mem_valid is high and mem_ready is low, mem_addr and mem_wdata must remain stable.
- Latency: a store pushed at edge N into an empty buffer presents mem_valid = 1 after edge N (one cycle). There is no combinational path from memwrite to mem_valid.
- Simultaneous push and pop (not full): both occur; count is unchanged; pointers advance independently.
- Pop when count == 1 with no push: empty = 1 after the edge, mem_valid = 0.
- Wrap-around: after DEPTH pushes and pops, pointers return to 0 with no loss or reordering. Memory sees stores in program order.
- Forwarding:
  - Compare lookup_addr[AW-1:2] against every valid entry's addr[AW-1:2].
  - fwd_hit = any match; fwd_data = data of the youngest match, i.e. the one nearest tail.
  - Forwarding is purely combinational on current contents. An entry being popped this cycle still forwards. A store being pushed this cycle does not forward.
- count and empty are registered state. align_err only ever sets in normal operation.

Test Plan:
- Reset (reset = 0 for 22 ns, then 1) → mem_valid = 0, count = 0, empty = 1, align_err = 0, stall = 0; after release, idle with mem_ready = 1 → nothing drains.
- Program store "sw $5,20($0)" with $5 = 0: memwrite = 1, dataadr = 20, writedata = 0, mem_ready = 0 → next cycle mem_valid = 1, mem_addr = 20, mem_wdata = 0, count = 1. Raise mem_ready → pop; next cycle empty = 1.
- Fill: mem_ready = 0, push addresses 0x10, 0x14, 0x18, 0x1C with data 1, 2, 3, 4 → count = 4; a fifth store (0x20, 5) gives stall = 1 and is not accepted. Then mem_ready = 1 → memory sees 0x10/1, 0x14/2, 0x18/3, 0x1C/4 on consecutive cycles; the retried 0x20/5 enqueues once stall drops and drains in order after 0x1C/4.
- Forwarding: buffer holds 0x40 = 0xAAAA then 0x40 = 0xBBBB, mem_ready = 0; lookup_addr = 0x42 → fwd_hit = 1, fwd_data = 0xBBBB; lookup_addr = 0x44 → fwd_hit = 0, fwd_data = 0.
- Misaligned plus wrap: store to dataadr = 0x15 → not enqueued, align_err = 1 (sticky), count unchanged. Then 10 push/pop pairs with mem_ready = 1 → every value is delivered in order across pointer wrap, and count never exceeds 1.
- Reset mid-drain: 3 entries queued, mem_valid = 1; assert reset between edges → mem_valid = 0 immediately and count = 0; after release, no stale entries ever appear at the memory.
